// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice.
package mem_responder_pkg;

  localparam int WORD_W   = 32;
  localparam int MAX_WAIT = 15;
  localparam int BE_W     = WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Word array behind mem_responder: one combinational read port and one
// synchronous byte-masked write port. Contents are not reset.
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
)(
  input  logic              clk,
  input  logic [BE_W-1:0]   i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  // Replace only the bytes whose enable is set; the rest keep their value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (i_we[i]) begin
        r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Handshaked memory responder: accepts one request, waits WAIT_CYCLES wait
// states, performs the access, then returns data/error on the response port.
// Optional feature macro: MEM_RESPONDER_WRITE_RSP_EN. When defined, stores
// are answered through the response port like loads; when undefined, stores
// are posted and never produce a response.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_count;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [WORD_W-1:0] r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_access;
  logic              w_err;
  logic              w_postStore;
  logic [AW-1:0]     w_wordIdx;
  logic [BE_W-1:0]   w_we;
  logic [WORD_W-1:0] w_ramRdata;

`ifdef MEM_RESPONDER_WRITE_RSP_EN
  assign w_postStore = 1'b0;
`else
  assign w_postStore = r_write;
`endif

  // req_ready is forced low while reset is held so nothing slips in during reset.
  assign req_ready = (r_state == IDLE) && reset;
  assign w_accept  = req_valid && req_ready;

  // The access happens on the edge that leaves WAIT, i.e. when the counter has run out.
  assign w_access  = (r_state == WAIT) && (r_count == '0);
  assign w_err     = (r_addr[1:0] != 2'b00) ||
                     ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_wordIdx = r_addr[AW+1:2];

  // Gating with reset keeps a store from committing on an edge where reset is sampled low.
  assign w_we = (w_access && r_write && !w_err && reset) ? r_be : '0;

  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  mem_responder_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wordIdx),
    .i_wdata (r_wdata),
    .i_raddr (w_wordIdx),
    .o_rdata (w_ramRdata)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state selection; posted stores skip RESP entirely.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (r_count == '0) begin
          w_nextState = w_postStore ? IDLE : RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_count <= WAIT_INIT;
      end else if ((r_state == WAIT) && (r_count != '0)) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_write) ? '0 : w_ramRdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. A transaction-level model predicts
// when each response appears and what it carries; a single negedge process
// compares the DUT against it every cycle. Directed sections pin the model
// with hand-computed values, then a randomized phase runs against the model.
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int WC    = 2;
`ifdef MEM_RESPONDER_WRITE_RSP_EN
  localparam bit WRITE_RSP = 1'b1;
`else
  localparam bit WRITE_RSP = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be    = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int assertCount = 0;
  int failCount   = 0;

  // Model state: word contents and the single outstanding transaction.
  logic [31:0] modelMem [DEPTH];
  int          cyc       = 0;
  bit          started   = 1'b0;
  bit          lastRst   = 1'b0;
  bit          pend      = 1'b0;
  bit          pendDone  = 1'b0;
  bit          pendWrite = 1'b0;
  bit          pendPosted = 1'b0;
  logic [31:0] pendAddr  = '0;
  logic [31:0] pendWdata = '0;
  logic [3:0]  pendBe    = '0;
  logic [31:0] expData   = '0;
  bit          expErr    = 1'b0;
  int          respEdge  = 0;
  int          acceptEdge = 0;
  bit          idleNow   = 1'b0;
  logic [31:0] lastRspData = '0;
  logic        lastRspErr  = 1'b0;
  int          dutRiseEdge = 0;
  logic        prevValid   = 1'b0;
  bit          randRsp     = 1'b0;

  mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Runaway guard so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportTimeout(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: got no event within budget, expected event (cycle %0d)", name, cyc);
  endtask

  function automatic bit addrErr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  // Edge bookkeeping: cycle count and the reset value sampled by each edge.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    lastRst <= reset;
    if (!reset) started <= 1'b1;
  end

  // Compare process: derive expected outputs from the transaction model every cycle.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && prevValid !== 1'b1) dutRiseEdge = cyc;
    prevValid = rsp_valid;
    if (started) begin
      if (!lastRst) begin
        checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("resetRspData",  rsp_rdata,      32'd0);
        checkOutput("resetRspErr",   32'(rsp_err),   32'd0);
      end
      if (!reset) begin
        checkOutput("resetReqReady", 32'(req_ready), 32'd0);
        pend = 1'b0;
      end else begin
        if (lastRst && pend && !pendDone && cyc >= respEdge) begin
          if (pendWrite && !expErr) begin
            for (int i = 0; i < 4; i++) begin
              if (pendBe[i]) modelMem[int'(pendAddr >> 2)][8*i +: 8] = pendWdata[8*i +: 8];
            end
          end
          pendDone = 1'b1;
          if (pendPosted) pend = 1'b0;
        end
        idleNow = !pend;
        if (lastRst) begin
          if (!pend) begin
            checkOutput("idleReqReady", 32'(req_ready), 32'd1);
            checkOutput("idleRspValid", 32'(rsp_valid), 32'd0);
          end else if (!pendDone) begin
            checkOutput("busyReqReady", 32'(req_ready), 32'd0);
            checkOutput("busyRspValid", 32'(rsp_valid), 32'd0);
          end else begin
            checkOutput("rspValid",    32'(rsp_valid), 32'd1);
            checkOutput("rspReqReady", 32'(req_ready), 32'd0);
            checkOutput("rspData",     rsp_rdata,      expData);
            checkOutput("rspErr",      32'(rsp_err),   32'(expErr));
            if (cyc == respEdge) begin
              lastRspData = rsp_rdata;
              lastRspErr  = rsp_err;
            end
            if (rsp_ready) pend = 1'b0;
          end
        end
        if (idleNow && req_valid) begin
          pend       = 1'b1;
          pendDone   = 1'b0;
          pendWrite  = req_write;
          pendPosted = req_write && !WRITE_RSP;
          pendAddr   = req_addr;
          pendWdata  = req_wdata;
          pendBe     = req_be;
          acceptEdge = cyc + 1;
          respEdge   = cyc + 1 + WC + 1;
          expErr     = addrErr(req_addr);
          expData    = (req_write || expErr) ? 32'd0 : modelMem[int'(req_addr >> 2)];
        end
      end
    end
  end

  // Background random response backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randRsp) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one request and hold it until the handshake completes.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) reportTimeout("acceptTimeout");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom_range(0, 15));
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!pend) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) reportTimeout("idleTimeout");
  endtask

  initial begin
    int r;
    logic [31:0] a;
    bit seen;

    $display("[TB] mem_responder bench start, WAIT_CYCLES=%0d WRITE_RSP=%0d", WC, WRITE_RSP);

    // Reset held for two edges.
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reqReadyInReset", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reqReadyAfterRelease", 32'(req_ready), 32'd1);
    checkOutput("rspValidAfterRelease", 32'(rsp_valid), 32'd0);
    checkOutput("rspDataAfterRelease",  rsp_rdata,      32'd0);

    // Fill every word so later loads have defined contents.
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'(i * 4), $urandom, 4'hF);
    end
    waitIdle();

    // Store then load, with latency measured on the DUT.
    applyStimulus(1'b1, 32'd100, 32'd7, 4'hF);
    waitIdle();
    applyStimulus(1'b0, 32'd100, 32'd0, 4'h0);
    waitIdle();
    checkOutput("load100Data", lastRspData, 32'd7);
    checkOutput("load100Err", 32'(lastRspErr), 32'd0);
    checkOutput("loadLatency", 32'(dutRiseEdge - acceptEdge), 32'd3);

    // Byte mask, then an all-zero mask that must change nothing.
    applyStimulus(1'b1, 32'd96, 32'h11223344, 4'hF);
    applyStimulus(1'b1, 32'd96, 32'hAABBCCDD, 4'b0101);
    applyStimulus(1'b0, 32'd96, 32'd0, 4'h0);
    waitIdle();
    checkOutput("byteMaskData", lastRspData, 32'h11BB33DD);
    checkOutput("byteMaskModel", modelMem[24], 32'h11BB33DD);
    applyStimulus(1'b1, 32'd96, 32'h99999999, 4'b0000);
    applyStimulus(1'b0, 32'd96, 32'd0, 4'h0);
    waitIdle();
    checkOutput("zeroBeData", lastRspData, 32'h11BB33DD);

    // Misaligned load.
    applyStimulus(1'b0, 32'd102, 32'd0, 4'h0);
    waitIdle();
    checkOutput("misalignErr", 32'(lastRspErr), 32'd1);
    checkOutput("misalignData", lastRspData, 32'd0);

    // Reset one cycle after accepting a store: the store must not land.
    applyStimulus(1'b1, 32'd0, 32'h12345678, 4'hF);
    waitIdle();
    applyStimulus(1'b1, 32'd0, 32'h0000DEAD, 4'hF);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0);
    waitIdle();
    checkOutput("resetInWaitData", lastRspData, 32'h12345678);

    // Out-of-range store: no array change (word 0 would alias if unguarded).
    applyStimulus(1'b1, 32'd256, 32'hFFFFFFFF, 4'hF);
    waitIdle();
`ifdef MEM_RESPONDER_WRITE_RSP_EN
    checkOutput("storeOorErr", 32'(lastRspErr), 32'd1);
`endif
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0);
    waitIdle();
    checkOutput("oorNoAlias", lastRspData, 32'h12345678);

    // Backpressure: response held for five cycles with a stray request pulse.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'd100, 32'd0, 4'h0);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportTimeout("bpRspTimeout");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      req_valid = (k == 1);
      req_write = 1'b1;
      req_addr  = 32'd100;
      req_wdata = 32'h55;
      req_be    = 4'hF;
      @(negedge clk);
      checkOutput("bpRspValid", 32'(rsp_valid), 32'd1);
      checkOutput("bpData",     rsp_rdata,      32'd7);
      checkOutput("bpReqReady", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    waitIdle();
    applyStimulus(1'b0, 32'd100, 32'd0, 4'h0);
    waitIdle();
    checkOutput("bpPulseIgnored", lastRspData, 32'd7);

    // Randomized traffic with random backpressure and back-to-back requests.
    randRsp = 1'b1;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      r = int'($urandom_range(0, 9));
      if (r <= 6)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'(DEPTH * 4) + (32'($urandom_range(0, 15)) << 2);
      else             a = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    randRsp = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    waitIdle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
